// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
//   state_t : sequencer state encoding (2'd3 is unused and recovers to S_IDLE)
//   NIBBLE  : slice width handled by the shared adder per clock
package nibble_serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned NIBBLE = 4;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle between the lab top level and the adder sequencer.
//   master : drives start/a/b/cin, observes busy/done/sum/cout
//   slave  : the sequencer side
interface nibble_serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/nibble_serial_adder_ctrl_fa4.sv
// FullAdder_4bits_in_nor: combinational 4-bit ripple adder built only from
// NOR gates.
//   i_a, i_b : nibble operands
//   i_cin    : carry in
//   o_sum    : nibble sum
//   o_cout   : carry out of bit 3
module FullAdder_4bits_in_nor
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE-1:0] i_a,
  input  logic [NIBBLE-1:0] i_b,
  input  logic              i_cin,
  output logic [NIBBLE-1:0] o_sum,
  output logic              o_cout
);
  logic [NIBBLE:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < NIBBLE; i++) begin : g_bit
    logic w_nab, w_p, w_q, w_xn, w_m, w_r, w_s, w_nbc, w_nac;
    // xnor(a,b) from four NORs
    assign w_nab = ~(i_a[i] | i_b[i]);
    assign w_p   = ~(i_a[i] | w_nab);
    assign w_q   = ~(i_b[i] | w_nab);
    assign w_xn  = ~(w_p | w_q);
    // xnor(xnor(a,b), c) == a ^ b ^ c
    assign w_m   = ~(w_xn | w_c[i]);
    assign w_r   = ~(w_xn | w_m);
    assign w_s   = ~(w_c[i] | w_m);
    assign o_sum[i] = ~(w_r | w_s);
    // majority(a,b,c) = NOR of the three pairwise NORs
    assign w_nbc = ~(i_b[i] | w_c[i]);
    assign w_nac = ~(i_a[i] | w_c[i]);
    assign w_c[i+1] = ~(w_nab | w_nbc | w_nac);
  end

  assign o_cout = w_c[NIBBLE];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds two WIDTH-bit operands through one shared
// 4-bit NOR ripple adder, one nibble per clock, LSB nibble first.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus.start  : request, accepted only in IDLE/DONE (busy low)
//   bus.a/b/cin: operands, captured on the accepted-start edge
//   bus.busy   : high while nibbles are being added
//   bus.done   : one-cycle pulse, sum/cout valid
//   bus.sum    : result modulo 2^WIDTH, held until the next accepted start
//   bus.cout   : carry out of bit WIDTH-1, held like sum
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int unsigned NIB   = WIDTH / NIBBLE;
  localparam int unsigned CNT_W = $clog2(NIB);

  state_t                  r_state, w_state_nxt;
  logic [WIDTH-1:0]        r_a_sh, r_b_sh;
  // Only the upper WIDTH-4 bits of the sum shift register are ever read back;
  // the newest nibble comes straight from the adder.
  logic [WIDTH-NIBBLE-1:0] r_sum_sh;
  logic [WIDTH-1:0]        r_sum;
  logic                    r_carry, r_cout, r_busy, r_done;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_accept, w_last, w_busy_nxt, w_done_nxt;
  logic [NIBBLE-1:0]       w_add_sum;
  logic                    w_add_cout;
  logic [WIDTH-1:0]        w_sum_shifted;

  FullAdder_4bits_in_nor u_fa4 (
    .i_a    (r_a_sh[NIBBLE-1:0]),
    .i_b    (r_b_sh[NIBBLE-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  assign w_accept      = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last        = (r_state == S_RUN) && (r_cnt == CNT_W'(NIB - 1));
  assign w_sum_shifted = {w_add_sum, r_sum_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // busy/done are registered copies of the next state, so they can never
  // overlap and done lasts exactly the one DONE cycle.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_RUN:   w_busy_nxt = 1'b1;
      S_DONE:  w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_accept) begin
        r_a_sh  <= bus.a;
        r_b_sh  <= bus.b;
        r_carry <= bus.cin;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_a_sh   <= r_a_sh >> NIBBLE;
        r_b_sh   <= r_b_sh >> NIBBLE;
        r_sum_sh <= w_sum_shifted[WIDTH-1:NIBBLE];
        r_carry  <= w_add_cout;
        if (w_last) begin
          r_sum  <= w_sum_shifted;
          r_cout <= w_add_cout;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule
